bus_pipe_stage: RTL

Parametrised successor to the fixed-width bus register block. It is an elastic, bubble-collapsing register pipeline of STAGES depth, WIDTH bits wide, with a valid/ready handshake on both sides. It also has a synchronous flush, an occupancy output and an output transfer counter. It sits between bus producers and consumers that need registered timing plus backpressure.

---
 rtl/bus_pipe_stage.sv | 80 ++++++++
 1 files changed

// File: rtl/bus_pipe_stage.sv
// Elastic valid/ready register pipeline. Bubbles collapse. It also has a
// synchronous flush, a registered occupancy output and an output transfer counter.
module bus_pipe_stage #(
    parameter int WIDTH   = 32,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 16
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           IN_VALID,
    output logic                           IN_READY,
    input  logic [WIDTH-1:0]               IN_DATA,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [WIDTH-1:0]               OUT_DATA,
    input  logic                           FLUSH,
    output logic [$clog2(STAGES+1)-1:0]    OCCUPANCY,
    output logic [COUNT_W-1:0]             XFER_COUNT
);
    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0]             v_q, v_d, adv, load;
    logic [STAGES-1:0][WIDTH-1:0]  d_q, d_d;
    logic [OCC_W-1:0]              occ_q, occ_d;
    logic [COUNT_W-1:0]            cnt_q, cnt_d;
    logic                          in_acc, xfer;

    // A stage advances when some stage above it has a hole, or when every
    // stage above it is full and the consumer takes a word. This is the
    // ready chain unrolled from the output end.
    always_comb begin
        logic above_full;
        above_full = 1'b1;
        adv        = '0;
        for (int i = STAGES-1; i >= 0; i--) begin
            adv[i]     = v_q[i] & (~above_full | OUT_READY);
            above_full = above_full & v_q[i];
        end
    end

    assign IN_READY   = ~FLUSH & (~v_q[0] | adv[0]);
    assign OUT_VALID  = v_q[STAGES-1] & ~FLUSH;
    assign OUT_DATA   = d_q[STAGES-1];
    assign OCCUPANCY  = occ_q;
    assign XFER_COUNT = cnt_q;
    assign in_acc     = IN_VALID & IN_READY;
    assign xfer       = OUT_VALID & OUT_READY;

    always_comb begin
        load    = '0;
        load[0] = in_acc;
        for (int i = 1; i < STAGES; i++)
            load[i] = adv[i-1] & ~FLUSH;

        d_d   = d_q;
        v_d   = '0;
        occ_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            v_d[i] = ~FLUSH & (load[i] | (v_q[i] & ~adv[i]));
            if (load[i])
                d_d[i] = (i == 0) ? IN_DATA : d_q[(i == 0) ? 0 : i-1];
            occ_d = occ_d + OCC_W'(v_d[i]);
        end
        cnt_d = cnt_q + COUNT_W'(xfer);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            v_q   <= '0;
            d_q   <= '0;
            occ_q <= '0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            occ_q <= occ_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
